// File: rtl/pll_lock_supervisor.sv
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Drives the PLL reset, qualifies the synchronized lock signal
//                over a stability window, retries on timeout, and releases the
//                system reset only while lock is held.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 50,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int CNT_W          = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic       fail
);

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       C_MAX_RETRIES  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [3:0]             r_retry;
  logic [3:0]             w_retry_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  logic r_pll_rst;
  logic r_sys_rst_n;
  logic r_lock_ok;
  logic r_lock_lost;
  logic r_fail;
  logic w_pll_rst_nxt;
  logic w_run_nxt;
  logic w_lock_lost_nxt;
  logic w_fail_nxt;

  // pll_locked is asynchronous to refclk; only the last stage is used.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_ok   <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst_n <= w_run_nxt;
      r_lock_ok   <= w_run_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;

    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (w_locked_s) begin
          w_state_nxt = ST_STABILIZE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry == C_MAX_RETRIES) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_RESET_PLL;
            if (r_retry < C_MAX_RETRIES) begin
              w_retry_nxt = r_retry + 4'd1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_STABILIZE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
        end
      end

      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_RESET_PLL;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end

      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end

      default: begin
        w_state_nxt = ST_RESET_PLL;
        w_cnt_nxt   = '0;
        w_retry_nxt = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the same edge.
    w_pll_rst_nxt   = (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
    w_run_nxt       = (w_state_nxt == ST_RUN);
    w_lock_lost_nxt = (r_state == ST_RUN) && !w_locked_s;
    w_fail_nxt      = (w_state_nxt == ST_FAIL);
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst_n   = r_sys_rst_n;
  assign lock_ok     = r_lock_ok;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;
  assign fail        = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
//  Module      : tb_pll_lock_supervisor
//  Description : Randomized and directed bench for pll_lock_supervisor with a
//                phase/countdown reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

  localparam int N    = 4;
  localparam int T    = 100;
  localparam int S    = 16;
  localparam int MAXR = 2;
  localparam int SS   = 2;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic       fail;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .SYNC_STAGES   (SS),
    .PLL_RST_CYCLES(N),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (MAXR),
    .CNT_W         (17)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .lock_ok    (lock_ok),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .fail       (fail)
  );

  // Reference model: named phase plus cycles left in it; lock seen SS edges late.
  string m_phase;
  int    m_left;
  int    m_retries;
  bit    m_lost;
  bit    m_ls;
  bit    lk_q[$];

  task automatic model_reset();
    m_phase   = "RESET";
    m_left    = N;
    m_retries = 0;
    m_lost    = 1'b0;
    lk_q      = {};
    for (int i = 0; i < SS; i++) lk_q.push_back(1'b0);
  endtask

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ls = lk_q.pop_front();
      lk_q.push_back(pll_locked);
      m_lost = 1'b0;
      if (m_phase == "RESET") begin
        m_left--;
        if (m_left == 0) begin
          m_phase = "WAIT";
          m_left  = T;
        end
      end else if (m_phase == "WAIT") begin
        if (m_ls) begin
          m_phase = "STAB";
          m_left  = S;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retries == MAXR) begin
              m_phase = "GIVEUP";
            end else begin
              m_retries++;
              m_phase = "RESET";
              m_left  = N;
            end
          end
        end
      end else if (m_phase == "STAB") begin
        if (!m_ls) begin
          m_phase = "WAIT";
          m_left  = T;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase   = "RUN";
            m_retries = 0;
          end
        end
      end else if (m_phase == "RUN") begin
        if (!m_ls) begin
          m_lost    = 1'b1;
          m_phase   = "RESET";
          m_left    = N;
          m_retries = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("m_pll_rst",   32'(pll_rst),     32'((m_phase == "RESET") || (m_phase == "GIVEUP")));
    check("m_sys_rst_n", 32'(sys_rst_n),   32'(m_phase == "RUN"));
    check("m_lock_ok",   32'(lock_ok),     32'(m_phase == "RUN"));
    check("m_lock_lost", 32'(lock_lost),   32'(m_lost));
    check("m_retry",     32'(retry_count), 32'(m_retries));
    check("m_fail",      32'(fail),        32'(m_phase == "GIVEUP"));
  endtask

  // Compare at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge refclk);
    cmp_model();
    @(posedge refclk);
    #2;
  endtask

  task automatic wait_release(input string name);
    int c;
    c = 0;
    while (!sys_rst_n && c < 300) begin
      tick();
      c++;
    end
    check(name, 32'(sys_rst_n), 32'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int c2;
    int e;
    int r0;
    int len;
    int r;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (3) @(posedge refclk);
    #2;
    check("rst_pll_rst",   32'(pll_rst),     32'(1));
    check("rst_sys_rst_n", 32'(sys_rst_n),   32'(0));
    check("rst_retry",     32'(retry_count), 32'(0));
    check("rst_fail",      32'(fail),        32'(0));
    rst_n = 1'b1;

    // 1: lock 10 cycles after pll_rst falls
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (pll_rst) c++;
      tick();
    end
    check("t1_pll_rst_len", 32'(c), 32'(4));
    check("t1_pll_rst_low", 32'(pll_rst), 32'(0));
    repeat (10) tick();
    pll_locked = 1'b1;
    c = 0;
    while (!sys_rst_n && c < 100) begin
      tick();
      c++;
    end
    check("t1_release_latency", 32'(c), 32'(19));
    check("t1_lock_ok", 32'(lock_ok), 32'(1));
    check("t1_retry", 32'(retry_count), 32'(0));

    // 4: lock dropped in RUN
    pll_locked = 1'b0;
    c  = 0;
    c2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (lock_lost) begin
        c++;
        check("t4_sys_rst_n_on_lost", 32'(sys_rst_n), 32'(0));
      end
      if (pll_rst) c2++;
    end
    check("t4_lost_width", 32'(c), 32'(1));
    check("t4_pll_rst_len", 32'(c2), 32'(4));
    pll_locked = 1'b1;
    wait_release("t4_relock");

    // 3: 5-cycle lock glitch in WAIT_LOCK
    pll_locked = 1'b0;
    repeat (20) tick();
    r0 = 32'(retry_count);
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    c = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sys_rst_n) c++;
    end
    check("t3_no_release", 32'(c), 32'(0));
    check("t3_retry_same", 32'(retry_count), 32'(r0));
    pll_locked = 1'b1;
    wait_release("t3_release");

    // 5: async reset mid-STABILIZE
    pll_locked = 1'b0;
    repeat (12) tick();
    pll_locked = 1'b1;
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    check("t5_pll_rst",   32'(pll_rst),     32'(1));
    check("t5_sys_rst_n", 32'(sys_rst_n),   32'(0));
    check("t5_lock_ok",   32'(lock_ok),     32'(0));
    check("t5_lock_lost", 32'(lock_lost),   32'(0));
    check("t5_retry",     32'(retry_count), 32'(0));
    check("t5_fail",      32'(fail),        32'(0));
    pll_locked = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      if (pll_rst) c++;
      tick();
    end
    check("t5_restart_pll_rst", 32'(c), 32'(4));

    // 2: lock never arrives
    do_reset();
    e = 0;
    c = 0;
    while (!fail && e < 400) begin
      if (pll_rst) c++;
      tick();
      e++;
    end
    check("t2_fail_edge", 32'(e), 32'(312));
    check("t2_pll_rst_cycles", 32'(c), 32'(12));
    check("t2_retry", 32'(retry_count), 32'(2));
    check("t2_pll_rst_fail", 32'(pll_rst), 32'(1));
    pll_locked = 1'b1;
    repeat (40) tick();
    check("t2_fail_sticky", 32'(fail), 32'(1));
    pll_locked = 1'b0;

    // 6: lock seen on the timeout cycle
    do_reset();
    repeat (101) tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    check("t6_retry", 32'(retry_count), 32'(0));
    check("t6_pll_rst", 32'(pll_rst), 32'(0));
    repeat (16) tick();
    check("t6_release", 32'(sys_rst_n), 32'(1));

    // Randomized lock behaviour with occasional board resets.
    for (int seg = 0; seg < 160; seg++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) do_reset();
      if (r < 3) begin
        pll_locked = 1'b0;
        len = int'($urandom_range(200, 400));
      end else if (r < 10) begin
        pll_locked = ~pll_locked;
        len = int'($urandom_range(1, 8));
      end else begin
        pll_locked = ~pll_locked;
        len = int'($urandom_range(10, 120));
      end
      repeat (len) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
